// File: rtl/pc_unit.sv
// Program-counter unit for the fetch stage: next-PC arbitration between trap,
// mret, redirect, stall and sequential flow, plus EPC and a circular return-address stack.
module pc_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'('h100),
    parameter int              RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            call_i,
    input  logic            ret_i,
    input  logic            trap_i,
    input  logic            mret_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic [XLEN-1:0] epc_o,
    output logic            misalign_o,
    output logic [XLEN-1:0] ras_top_o,
    output logic            ras_empty_o
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        SRC_SEQ,
        SRC_HOLD,
        SRC_REDIR,
        SRC_MISALIGN,
        SRC_MRET,
        SRC_TRAP
    } src_e;

    src_e            src;
    logic [XLEN-1:0] pc_q, pc_n;
    logic [XLEN-1:0] epc_q, epc_n;
    logic            mis_q, mis_n;
    logic [XLEN-1:0] redirect_aligned;

    logic [XLEN-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]   ras_ptr, ras_ptr_n, ras_waddr;
    logic [CW-1:0]   ras_cnt, ras_cnt_n;
    logic            ras_push, ras_pop, ras_we;

    assign pc_plus4_o       = pc_q + XLEN'(4);
    assign redirect_aligned = redirect_pc_i & ~XLEN'(1);

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        src = SRC_SEQ;
        if (trap_i)                             src = SRC_TRAP;
        else if (mret_i)                        src = SRC_MRET;
        else if (redirect_i && redirect_pc_i[1]) src = SRC_MISALIGN;
        else if (redirect_i)                    src = SRC_REDIR;
        else if (stall_i)                       src = SRC_HOLD;

        pc_n  = pc_plus4_o;
        epc_n = epc_q;
        mis_n = mis_q;
        unique case (src)
            SRC_TRAP: begin
                pc_n  = TRAP_VEC;
                epc_n = pc_q;
                mis_n = 1'b0;
            end
            SRC_MRET: begin
                pc_n  = epc_q;
                mis_n = 1'b0;
            end
            SRC_MISALIGN: begin
                pc_n  = TRAP_VEC;
                epc_n = redirect_aligned;
                mis_n = 1'b1;
            end
            SRC_REDIR: pc_n = redirect_aligned;
            SRC_HOLD:  pc_n = pc_q;
            default:   pc_n = pc_plus4_o;
        endcase
    end

    // Call+return on a non-empty stack rewrites the top in place; on an empty
    // stack the pop is a no-op, so it degenerates to a plain push.
    always_comb begin
        ras_push  = (src == SRC_REDIR) && call_i;
        ras_pop   = (src == SRC_REDIR) && ret_i;
        ras_ptr_n = ras_ptr;
        ras_cnt_n = ras_cnt;
        ras_waddr = ras_ptr;
        ras_we    = 1'b0;
        if (ras_push && ras_pop && ras_cnt != '0) begin
            ras_we = 1'b1;
        end else if (ras_push) begin
            ras_ptr_n = ras_ptr + PW'(1);
            ras_waddr = ras_ptr + PW'(1);
            ras_we    = 1'b1;
            if (ras_cnt != CW'(RAS_DEPTH)) ras_cnt_n = ras_cnt + CW'(1);
        end else if (ras_pop && ras_cnt != '0) begin
            ras_ptr_n = ras_ptr - PW'(1);
            ras_cnt_n = ras_cnt - CW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q    <= RESET_VEC;
            epc_q   <= '0;
            mis_q   <= 1'b0;
            ras_ptr <= '0;
            ras_cnt <= '0;
        end else begin
            pc_q    <= pc_n;
            epc_q   <= epc_n;
            mis_q   <= mis_n;
            ras_ptr <= ras_ptr_n;
            ras_cnt <= ras_cnt_n;
        end
    end

    // NOTE: the stack storage is not reset; the count alone marks entries valid.
    always_ff @(posedge clk) begin
        if (rst_n && ras_we) ras_mem[ras_waddr] <= pc_plus4_o;
    end

    assign pc_o        = pc_q;
    assign epc_o       = epc_q;
    assign misalign_o  = mis_q;
    assign ras_empty_o = (ras_cnt == '0);
    assign ras_top_o   = ras_empty_o ? '0 : ras_mem[ras_ptr];

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: a behavioural model pushes expected state
// into a scoreboard queue each cycle, popped and compared after the clock edge.
module tb_pc_unit;

    localparam int          XLEN      = 32;
    localparam logic [31:0] RESET_VEC = 32'h0;
    localparam logic [31:0] TRAP_VEC  = 32'h100;
    localparam int          RAS_DEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] epc;
        logic        mis;
        logic [31:0] top;
        logic        empty;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, stall, redirect, call, ret, trap, mret;
    logic [31:0] redirect_pc;
    logic [31:0] pc, pc_plus4, epc, ras_top;
    logic        misalign, ras_empty;

    int total = 0;
    int bad   = 0;

    exp_t        sb[$];
    logic [31:0] m_pc, m_epc;
    logic        m_mis;
    logic [31:0] m_ras[$];

    pc_unit #(
        .XLEN(XLEN), .RESET_VEC(RESET_VEC), .TRAP_VEC(TRAP_VEC), .RAS_DEPTH(RAS_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall), .redirect_i(redirect),
        .redirect_pc_i(redirect_pc), .call_i(call), .ret_i(ret), .trap_i(trap),
        .mret_i(mret), .pc_o(pc), .pc_plus4_o(pc_plus4), .epc_o(epc),
        .misalign_o(misalign), .ras_top_o(ras_top), .ras_empty_o(ras_empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic ras_push_model(input logic [31:0] v);
        m_ras.push_back(v);
        if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
    endtask

    // One clock: drive inputs, advance the model, then compare after the edge.
    task automatic drive(input logic r, input logic st, input logic rd, input logic [31:0] rpc,
                         input logic cl, input logic rt, input logic tr, input logic mr);
        logic [31:0] p4;
        exp_t        e;
        rst_n = r; stall = st; redirect = rd; redirect_pc = rpc;
        call = cl; ret = rt; trap = tr; mret = mr;

        p4 = m_pc + 32'd4;
        if (!r) begin
            m_pc = RESET_VEC; m_epc = '0; m_mis = 1'b0; m_ras.delete();
        end else if (tr) begin
            m_epc = m_pc; m_pc = TRAP_VEC; m_mis = 1'b0;
        end else if (mr) begin
            m_pc = m_epc; m_mis = 1'b0;
        end else if (rd && rpc[1]) begin
            m_pc = TRAP_VEC; m_epc = {rpc[31:1], 1'b0}; m_mis = 1'b1;
        end else if (rd) begin
            m_pc = {rpc[31:1], 1'b0};
            if (rt && m_ras.size() > 0) void'(m_ras.pop_back());
            if (cl) ras_push_model(p4);
        end else if (!st) begin
            m_pc = p4;
        end
        e.pc    = m_pc;
        e.epc   = m_epc;
        e.mis   = m_mis;
        e.empty = (m_ras.size() == 0);
        e.top   = e.empty ? 32'h0 : m_ras[m_ras.size()-1];
        sb.push_back(e);

        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("pc", pc, e.pc);
        check("pc_plus4", pc_plus4, e.pc + 32'd4);
        check("epc", epc, e.epc);
        check("misalign", {31'b0, misalign}, {31'b0, e.mis});
        check("ras_top", ras_top, e.top);
        check("ras_empty", {31'b0, ras_empty}, {31'b0, e.empty});
    endtask

    task automatic idle();
        drive(1, 0, 0, 32'h0, 0, 0, 0, 0);
    endtask

    task automatic redir(input logic [31:0] t, input logic cl, input logic rt);
        drive(1, 0, 1, t, cl, rt, 0, 0);
    endtask

    initial begin
        m_pc = '0; m_epc = '0; m_mis = 1'b0;
        rst_n = 1'b0; stall = 0; redirect = 0; redirect_pc = '0;
        call = 0; ret = 0; trap = 0; mret = 0;

        // Reset, then free-running 4, 8, 12.
        drive(0, 0, 0, 32'h0, 0, 0, 0, 0);
        repeat (3) idle();

        // Redirect beats stall; stall alone holds.
        redir(32'h40, 0, 0);
        drive(1, 1, 1, 32'h80, 0, 0, 0, 0);
        redir(32'h40, 0, 0);
        drive(1, 1, 0, 32'h0, 0, 0, 0, 0);
        drive(1, 1, 0, 32'h0, 0, 0, 0, 0);

        // Trap / mret, then all three together with a call (trap wins, RAS untouched).
        redir(32'h20, 0, 0);
        drive(1, 0, 0, 32'h0, 0, 0, 1, 0);
        drive(1, 0, 0, 32'h0, 0, 0, 0, 1);
        drive(1, 1, 1, 32'h80, 1, 0, 1, 1);
        drive(1, 0, 1, 32'h80, 0, 0, 0, 1);

        // Misaligned redirect traps; bit0-only is cleared and taken.
        redir(32'h1002, 1, 0);
        redir(32'h201, 1, 0);
        redir(32'h1003, 0, 0);
        drive(1, 0, 0, 32'h0, 0, 0, 0, 1);

        // Five calls overflow a 4-deep stack, then five returns.
        redir(32'h10, 0, 0);
        redir(32'h20, 1, 0);
        redir(32'h30, 1, 0);
        redir(32'h40, 1, 0);
        redir(32'h50, 1, 0);
        redir(32'h60, 1, 0);
        drive(1, 0, 0, 32'h0, 1, 1, 0, 0);
        drive(1, 0, 0, 32'h0, 0, 0, 1, 0);
        repeat (5) redir(32'h300, 0, 1);

        // Call+return replaces the top without changing depth.
        redir(32'h400, 1, 0);
        redir(32'h500, 1, 1);
        redir(32'h600, 0, 1);

        // Wrap at the top of the address space.
        redir(32'hFFFF_FFFC, 0, 0);
        idle();
        idle();

        // Reset during a call.
        redir(32'h40, 1, 0);
        drive(0, 0, 1, 32'h80, 1, 0, 0, 0);

        // Random traffic, biased toward redirects with call/return.
        for (int i = 0; i < 200; i++) begin
            logic [31:0] t;
            t = $urandom_range(0, 32'hFFF);
            drive(($urandom_range(0, 40) != 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 1) == 1), t,
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0));
        end

        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
